// File: rtl/outport_arbiter_if.sv
// Handshake bundle between the input-port side and one output-port arbiter.
// OUTPORT_ARB_TIMEOUT_EN adds the sticky timeout_flag signal.
interface outport_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned CNT_W     = 3
);
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] tail;
    logic                 credit_in;
    logic [NUM_PORTS-1:0] grant;
    logic [SEL_W-1:0]     xbar_sel;
    logic                 arb_ack;
    logic                 busy;
    logic [CNT_W-1:0]     credit_cnt;
    logic                 credit_err;
`ifdef OUTPORT_ARB_TIMEOUT_EN
    logic                 timeout_flag;

    modport master (
        output req, tail, credit_in,
        input  grant, xbar_sel, arb_ack, busy, credit_cnt, credit_err, timeout_flag
    );
    modport slave (
        input  req, tail, credit_in,
        output grant, xbar_sel, arb_ack, busy, credit_cnt, credit_err, timeout_flag
    );
`else
    modport master (
        output req, tail, credit_in,
        input  grant, xbar_sel, arb_ack, busy, credit_cnt, credit_err
    );
    modport slave (
        input  req, tail, credit_in,
        output grant, xbar_sel, arb_ack, busy, credit_cnt, credit_err
    );
`endif
endinterface

// File: rtl/outport_arbiter.sv
// Round-robin, packet-locked output-port arbiter with downstream credit tracking.
// Optional forced release of a silent owner under OUTPORT_ARB_TIMEOUT_EN.
module outport_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned CREDITS   = 4,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned TIMEOUT   = 16
) (
    input logic               clk,
    input logic               rst,
    outport_arbiter_if.slave  arb_io
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam logic [CNT_W-1:0] CreditsMax = CNT_W'(CREDITS);
    localparam logic [SEL_W-1:0] LastPort   = SEL_W'(NUM_PORTS - 1);

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     credit_cnt_q, credit_cnt_d;
    logic                 credit_err_q, credit_err_d;

    logic                 found;
    logic [SEL_W-1:0]     win_idx;
    logic                 has_credit;
    logic                 xfer;
    logic                 release_pkt;
    logic [SEL_W-1:0]     next_ptr;

    assign has_credit = (credit_cnt_q != '0);
    assign xfer       = (state_q == StLocked) && arb_io.req[sel_q] && has_credit;
    assign next_ptr   = (sel_q == LastPort) ? '0 : sel_q + SEL_W'(1);

    // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        int unsigned idx;
        logic [SEL_W-1:0] idx_s;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        idx_s   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx   = (32'(rr_ptr_q) + i) % NUM_PORTS;
            idx_s = SEL_W'(idx);
            if (!found && arb_io.req[idx_s]) begin
                found   = 1'b1;
                win_idx = idx_s;
            end
        end
    end

`ifdef OUTPORT_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);
    localparam logic [ToW-1:0] ToLimit = ToW'(TIMEOUT);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           to_flag_q, to_flag_d;
    logic           to_hit;

    assign to_hit = (state_q == StLocked) && !xfer && (to_cnt_q == ToLimit);

    // Only cycles where the owner itself is silent count; credit stalls hold the count.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        if (state_q != StLocked || xfer || to_hit) begin
            to_cnt_d = '0;
        end else if (!arb_io.req[sel_q]) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end
        if (to_hit) begin
            to_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign arb_io.timeout_flag = to_flag_q;
    assign release_pkt = (xfer && arb_io.tail[sel_q]) || to_hit;
`else
    assign release_pkt = xfer && arb_io.tail[sel_q];
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (found && has_credit) begin
                    state_d = StLocked;
                    grant_d = NUM_PORTS'(1) << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                end
            end
            StLocked: begin
                if (release_pkt) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A simultaneous transfer and credit return cancel out, even at the limits.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (xfer && !arb_io.credit_in) begin
            credit_cnt_d = credit_cnt_q - CNT_W'(1);
        end else if (!xfer && arb_io.credit_in) begin
            if (credit_cnt_q == CreditsMax) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            sel_q        <= '0;
            busy_q       <= 1'b0;
            rr_ptr_q     <= '0;
            credit_cnt_q <= CreditsMax;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign arb_io.grant      = grant_q;
    assign arb_io.xbar_sel   = sel_q;
    assign arb_io.busy       = busy_q;
    assign arb_io.arb_ack    = xfer;
    assign arb_io.credit_cnt = credit_cnt_q;
    assign arb_io.credit_err = credit_err_q;

endmodule

// File: doc/outport_arbiter.md
Name: outport_arbiter

Overview:
- Per-output-port round-robin arbiter of the router, directly upstream of the output port.
- Selects one of NUM_PORTS input ports and drives the crossbar select.
- Holds the grant for the whole packet, head flit through tail flit.
- Tracks downstream buffer credits and issues the per-flit arb_ack that the output port consumes alongside the crossbar data.

Parameters:
- NUM_PORTS, 4, number of competing input ports (2..8).
- SEL_W, 2, width of xbar_sel; must equal ceil(log2(NUM_PORTS)).
- CREDITS, 4, downstream buffer depth in flits; also the credit counter reset value.
- CNT_W, 3, credit counter width; must hold the value CREDITS.
- TIMEOUT, 16, idle cycles before forced release (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- req  in  NUM_PORTS  per-input flit valid targeting this output.
- tail  in  NUM_PORTS  qualifies req[i]: the current flit of port i is a tail flit.
- credit_in  in  1  one downstream slot freed this cycle.
- grant  out  NUM_PORTS  one-hot owner of the output; registered.
- xbar_sel  out  SEL_W  binary index of the owner; registered.
- arb_ack  out  1  a flit transfers this cycle; combinational. Feeds the output port and the owner's pop.
- busy  out  1  high while a packet holds the output; registered.
- credit_cnt  out  CNT_W  available downstream credits; registered.
- credit_err  out  1  sticky flag: credit_in arrived with the counter already at CREDITS.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, grant=0, xbar_sel=0, busy=0, rr_ptr=0.
  - credit_cnt=CREDITS, credit_err=0.
  - arb_ack=0 while in reset.
- Reset mid-packet aborts the packet: the grant drops immediately and no tail flit is required.
- IDLE:
  - arb_ack=0.
  - If |req and credit_cnt!=0, pick the winner w: first set bit scanning from rr_ptr upward, wrapping modulo NUM_PORTS.
  - Next edge: grant=onehot(w), xbar_sel=w, busy=1, state=LOCKED.
  - If no req, or credit_cnt==0, stay in IDLE.
- LOCKED (owner o):
  - xfer = req[o] & (credit_cnt!=0); arb_ack = xfer.
  - req[o]=0 or no credits: stall. Grant is held, arb_ack=0, other requests are ignored.
  - On an edge with xfer & tail[o]: state=IDLE, grant=0, busy=0, rr_ptr=(o+1) mod NUM_PORTS.
  - The earliest new grant comes one cycle after release (one IDLE bubble per packet).
- Latency:
  - A req rising in IDLE produces grant on the next edge.
  - The first arb_ack is in that same granted cycle if req and credits are present.
  - Sustained throughput is 1 flit/cycle while credits last.
- Single-flit packet (head=tail): exactly one arb_ack cycle, then release.
- Credits:
  - credit_cnt_next = credit_cnt - xfer + credit_in.
  - xfer and credit_in in the same cycle leave the counter unchanged, including at 0 and at CREDITS.
  - credit_in alone at credit_cnt==CREDITS: counter holds and credit_err sets. credit_err clears only on reset.
  - Counter never underflows: xfer requires credit_cnt!=0.
- Fairness: rr_ptr advances only on packet completion, so every requester is served within NUM_PORTS-1 packets.
- tail bits are don't-care when the matching req is low.

Optional Feature:
- Macro: OUTPORT_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive LOCKED cycles with req[o]=0 (credit stalls excluded). It resets on any xfer or on entering LOCKED.
  - When it reaches TIMEOUT, the next edge forces release: state=IDLE, grant=0, busy=0, rr_ptr=(o+1) mod NUM_PORTS.
  - Sticky output timeout_flag (1 bit, reset 0) sets on a forced release.
- Not defined: no counter and no timeout_flag port. The grant is held indefinitely until the tail flit transfers.

Test Plan:
- Reset, then req=4'b0001 with a 3-flit packet (tail on the 3rd flit), CREDITS=4:
  - grant=0001 and xbar_sel=0 one cycle after req.
  - arb_ack high 3 consecutive cycles, credit_cnt 4→3→2→1.
  - grant=0 after the tail flit; rr_ptr=1.
- req=4'b1111, all single-flit packets, credit_in pulsed every cycle:
  - grants in order 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
  - credit_cnt stays constant.
- Owner 2 granted, 6-flit packet, no credit_in:
  - arb_ack on 4 flits, then a stall with grant=0100 held and credit_cnt=0.
  - A credit_in pulse gives exactly one further arb_ack on the next cycle.
- credit_cnt=0, then xfer and credit_in in the same cycle after a credit return: counter unchanged. Separately, credit_in at credit_cnt=4: counter stays 4 and credit_err=1.
- Mid-packet rst low for 1 cycle while owner 3 is on flit 2 of 4: grant=0, busy=0, credit_cnt=4 immediately; after release, arbitration restarts from port 0.
- With OUTPORT_ARB_TIMEOUT_EN and TIMEOUT=16: owner drops req after its head flit; release occurs 16 cycles later, timeout_flag=1, and the next requester is granted.
